// File: rtl/muldiv_sequencer_if.sv
// Request/response handshake bundle for the iterative multiply/divide unit.
// master: issuing pipeline stage; slave: muldiv_sequencer.
interface muldiv_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            flush;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output req_valid, op, rs1_val, rs2_val, flush, resp_ready,
        input  req_ready, resp_valid, result, busy
    );

    modport slave (
        input  req_valid, op, rs1_val, rs2_val, flush, resp_ready,
        output req_ready, resp_valid, result, busy
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M unsigned MUL/MULHU/DIVU/REMU unit, one bit per cycle, IDLE->RUN->DONE.
// Optional MULDIV_EARLY_OUT_EN: trivial operands finish after a single step.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input logic               clock,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);

    localparam int unsigned CntW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        OpMul   = 2'b00,
        OpMulhu = 2'b01,
        OpDivu  = 2'b10,
        OpRemu  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q;
    op_e               op_q;
    logic [CntW-1:0]   cnt_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   result_q;
    logic              resp_valid_q;
    logic              busy_q;
    logic              req_ready_q;

    logic [XLEN:0]     add_sum;
    logic [2*XLEN-1:0] prod_next;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     rem_diff;
    logic [XLEN-1:0]   rem_next;
    logic [XLEN-1:0]   quo_next;
    logic [XLEN-1:0]   final_res;

`ifdef MULDIV_EARLY_OUT_EN
    logic triv_q;

    function automatic logic is_trivial(input logic [1:0] op, input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
        if (op[1]) begin
            return (b == '0);
        end
        return (a == '0) || (b == '0);
    endfunction
`endif

    always_comb begin
        // Shift-add multiply: multiplier sits in the low half and is consumed LSB-first.
        add_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + ({1'b0, opnd_q} & {(XLEN+1){prod_q[0]}});
        prod_next = {add_sum, prod_q[XLEN-1:1]};

        // Restoring divide: quo_q holds the remaining dividend bits, MSB-first.
        rem_shift = {rem_q, quo_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, opnd_q};
        rem_next  = rem_diff[XLEN] ? rem_shift[XLEN-1:0] : rem_diff[XLEN-1:0];
        quo_next  = {quo_q[XLEN-2:0], ~rem_diff[XLEN]};

        case (op_q)
            OpMul:   final_res = prod_next[XLEN-1:0];
            OpMulhu: final_res = prod_next[2*XLEN-1:XLEN];
            OpDivu:  final_res = quo_next;
            default: final_res = rem_next;
        endcase

`ifdef MULDIV_EARLY_OUT_EN
        // quo_q still holds the untouched dividend on the single trivial step.
        if (triv_q) begin
            case (op_q)
                OpDivu:  final_res = '1;
                OpRemu:  final_res = quo_q;
                default: final_res = '0;
            endcase
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            op_q         <= OpMul;
            cnt_q        <= '0;
            opnd_q       <= '0;
            prod_q       <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            result_q     <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            req_ready_q  <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
            triv_q       <= 1'b0;
`endif
        end else if (bus.flush) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        op_q        <= op_e'(bus.op);
                        opnd_q      <= bus.op[1] ? bus.rs2_val : bus.rs1_val;
                        prod_q      <= {{XLEN{1'b0}}, bus.rs2_val};
                        quo_q       <= bus.rs1_val;
                        rem_q       <= '0;
                        state_q     <= StRun;
                        busy_q      <= 1'b1;
                        req_ready_q <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
                        triv_q <= is_trivial(bus.op, bus.rs1_val, bus.rs2_val);
                        cnt_q  <= is_trivial(bus.op, bus.rs1_val, bus.rs2_val) ?
                                  CntW'(1) : CntW'(XLEN);
`else
                        cnt_q  <= CntW'(XLEN);
`endif
                    end
                end
                StRun: begin
                    prod_q <= prod_next;
                    rem_q  <= rem_next;
                    quo_q  <= quo_next;
                    cnt_q  <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_q      <= StDone;
                        resp_valid_q <= 1'b1;
                        result_q     <= final_res;
                    end
                end
                StDone: begin
                    if (bus.resp_ready) begin
                        state_q      <= StIdle;
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.result     = result_q;
    assign bus.busy       = busy_q;

endmodule
